// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// At most one request is outstanding; the address is held until the ack pulse.
interface fetch_stage_if #(
    parameter int WL = 32
);
    logic          imem_req;
    logic [WL-1:0] imem_addr;
    logic          imem_ack;
    logic [WL-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, talks to imem over a req/ack bus
// and drives the IF/ID register with stall, redirect-flush and bubble handling.
module fetch_stage #(
    parameter int            WL       = 32,
    parameter logic [WL-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [WL-1:0] redirect_pc,
    fetch_stage_if.master imem,
    output logic [WL-1:0] if_id_instr,
    output logic [WL-1:0] if_id_pc4,
    output logic          if_id_valid
);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [WL-1:0] r_pc;
    logic [WL-1:0] w_pcNext;
    logic [WL-1:0] w_pcPlus4;
    logic          r_pending;
    logic          w_pendingNext;
    logic [WL-1:0] r_pendPc;
    logic [WL-1:0] w_pendPcNext;
    logic [WL-1:0] r_holdInstr;
    logic [WL-1:0] w_holdInstrNext;
    logic [WL-1:0] r_holdPc4;
    logic [WL-1:0] w_holdPc4Next;
    logic [WL-1:0] r_instr;
    logic [WL-1:0] w_instrNext;
    logic [WL-1:0] r_pc4;
    logic [WL-1:0] w_pc4Next;
    logic          r_valid;
    logic          w_validNext;
    logic          w_deliver;
    logic [WL-1:0] w_deliverInstr;
    logic [WL-1:0] w_deliverPc4;

    assign w_pcPlus4      = r_pc + WL'(4);
    assign imem.imem_req  = (r_state == FETCH);
    assign imem.imem_addr = r_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc4      = r_pc4;
    assign if_id_valid    = r_valid;

    always_comb begin
        w_stateNext     = r_state;
        w_pcNext        = r_pc;
        w_pendingNext   = r_pending;
        w_pendPcNext    = r_pendPc;
        w_holdInstrNext = r_holdInstr;
        w_holdPc4Next   = r_holdPc4;
        w_deliver       = 1'b0;
        w_deliverInstr  = imem.imem_rdata;
        w_deliverPc4    = w_pcPlus4;

        case (r_state)
            START: begin
                w_stateNext = FETCH;
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    // A response that raced a redirect belongs to the wrong path
                    if (redirect_i || r_pending) begin
                        w_pcNext      = redirect_i ? redirect_pc : r_pendPc;
                        w_pendingNext = 1'b0;
                    end else if (!stall_i) begin
                        w_deliver = 1'b1;
                        w_pcNext  = w_pcPlus4;
                    end else begin
                        w_holdInstrNext = imem.imem_rdata;
                        w_holdPc4Next   = w_pcPlus4;
                        w_stateNext     = HOLD;
                    end
                end else if (redirect_i) begin
                    w_pendingNext = 1'b1;
                    w_pendPcNext  = redirect_pc;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    w_pcNext        = redirect_pc;
                    w_holdInstrNext = '0;
                    w_holdPc4Next   = '0;
                    w_stateNext     = FETCH;
                end else if (!stall_i) begin
                    w_deliver      = 1'b1;
                    w_deliverInstr = r_holdInstr;
                    w_deliverPc4   = r_holdPc4;
                    w_pcNext       = r_holdPc4;
                    w_stateNext    = FETCH;
                end
            end
            default: begin
                w_stateNext = START;
            end
        endcase

        // IF/ID priority: redirect flush, then stall freeze, then load, else bubble
        w_instrNext = r_instr;
        w_pc4Next   = r_pc4;
        w_validNext = r_valid;
        if (redirect_i) begin
            w_validNext = 1'b0;
        end else if (stall_i) begin
            w_validNext = r_valid;
        end else if (w_deliver) begin
            w_instrNext = w_deliverInstr;
            w_pc4Next   = w_deliverPc4;
            w_validNext = 1'b1;
        end else begin
            w_validNext = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= START;
            r_pc        <= RESET_PC;
            r_pending   <= 1'b0;
            r_pendPc    <= '0;
            r_holdInstr <= '0;
            r_holdPc4   <= '0;
            r_instr     <= '0;
            r_pc4       <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_pending   <= w_pendingNext;
            r_pendPc    <= w_pendPcNext;
            r_holdInstr <= w_holdInstrNext;
            r_holdPc4   <= w_holdPc4Next;
            r_instr     <= w_instrNext;
            r_pc4       <= w_pc4Next;
            r_valid     <= w_validNext;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero/multi-wait fetch, stall, redirect,
// combined hazards, late ack after reset, async reset and PC wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rstW_n;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        memAuto;
    logic        manualAck;
    int          waitStates;
    int          waitCnt;
    int          total;
    int          bad;

    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] wInstr;
    logic [31:0] wPc4;
    logic        wValid;

    fetch_stage_if #(.WL(32)) mem ();
    fetch_stage_if #(.WL(32)) memW ();

    always #5 clk = ~clk;

    // Behavioural imem: auto mode answers after waitStates cycles, manual mode follows manualAck
    assign mem.imem_ack   = memAuto ? (mem.imem_req && (waitCnt == waitStates)) : manualAck;
    assign mem.imem_rdata = mem.imem_addr + 32'h1000_0000;
    assign memW.imem_ack   = memW.imem_req;
    assign memW.imem_rdata = memW.imem_addr + 32'h1000_0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) waitCnt <= 0;
        else if (!mem.imem_req || mem.imem_ack) waitCnt <= 0;
        else waitCnt <= waitCnt + 1;
    end

    fetch_stage #(.WL(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall),
        .redirect_i  (redirect),
        .redirect_pc (rpc),
        .imem        (mem),
        .if_id_instr (instr),
        .if_id_pc4   (pc4),
        .if_id_valid (valid)
    );

    fetch_stage #(.WL(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk         (clk),
        .rst_n       (rstW_n),
        .stall_i     (1'b0),
        .redirect_i  (1'b0),
        .redirect_pc (32'h0),
        .imem        (memW),
        .if_id_instr (wInstr),
        .if_id_pc4   (wPc4),
        .if_id_valid (wValid)
    );

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] target, input logic ack);
        stall     = st;
        redirect  = rd;
        rpc       = target;
        manualAck = ack;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        rstW_n = 1'b0;
        memAuto = 1'b1;
        waitStates = 0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

        // Reset state
        repeat (2) stepCycle();
        checkBit("rst_req", mem.imem_req, 1'b0);
        checkOutput("rst_addr", mem.imem_addr, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_pc4", pc4, 32'h0);
        checkBit("rst_valid", valid, 1'b0);

        // Zero-wait streaming
        rst_n = 1'b1;
        checkBit("start_req", mem.imem_req, 1'b0);
        stepCycle();
        checkBit("fetch_req", mem.imem_req, 1'b1);
        checkOutput("fetch_addr0", mem.imem_addr, 32'h0);
        checkBit("fetch_valid0", valid, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            stepCycle();
            checkOutput("zw_addr", mem.imem_addr, 32'(4 * i));
            checkOutput("zw_pc4", pc4, 32'(4 * i));
            checkBit("zw_valid", valid, 1'b1);
        end
        checkOutput("zw_instr", instr, 32'h1000_000C);

        // Two wait states: each address held three cycles, valid 0,0,1
        waitStates = 2;
        for (int r = 0; r < 2; r++) begin
            stepCycle();
            checkOutput("ws_addr_a", mem.imem_addr, 32'(16 + 4 * r));
            checkBit("ws_valid_a", valid, 1'b0);
            stepCycle();
            checkOutput("ws_addr_b", mem.imem_addr, 32'(16 + 4 * r));
            checkBit("ws_valid_b", valid, 1'b0);
            stepCycle();
            checkOutput("ws_addr_c", mem.imem_addr, 32'(20 + 4 * r));
            checkOutput("ws_pc4_c", pc4, 32'(20 + 4 * r));
            checkBit("ws_valid_c", valid, 1'b1);
        end

        // Async reset while waiting for ack at 0x18, no clock edge
        rst_n = 1'b0;
        #1;
        checkBit("arst_req", mem.imem_req, 1'b0);
        checkOutput("arst_addr", mem.imem_addr, 32'h0);
        checkOutput("arst_pc4", pc4, 32'h0);
        checkOutput("arst_instr", instr, 32'h0);
        checkBit("arst_valid", valid, 1'b0);

        // Stall for three cycles while the ack for 0x10 arrives
        waitStates = 0;
        stepCycle();
        rst_n = 1'b1;
        repeat (5) stepCycle();
        checkOutput("pre_stall_addr", mem.imem_addr, 32'h10);
        checkOutput("pre_stall_pc4", pc4, 32'h10);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkBit("stall_req", mem.imem_req, 1'b0);
            checkOutput("stall_pc4", pc4, 32'h10);
            checkBit("stall_valid", valid, 1'b1);
            checkOutput("stall_addr", mem.imem_addr, 32'h10);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        stepCycle();
        checkOutput("unstall_pc4", pc4, 32'h14);
        checkBit("unstall_valid", valid, 1'b1);
        checkOutput("unstall_instr", instr, 32'h1000_0010);
        checkOutput("unstall_addr", mem.imem_addr, 32'h14);
        checkBit("unstall_req", mem.imem_req, 1'b1);

        // Manual ack: advance to 0x20, then redirect while it is outstanding
        memAuto = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) stepCycle();
        checkOutput("man_addr", mem.imem_addr, 32'h20);
        checkOutput("man_pc4", pc4, 32'h20);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
        stepCycle();
        checkBit("redir_valid", valid, 1'b0);
        checkOutput("redir_addr_held", mem.imem_addr, 32'h20);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        stepCycle();
        checkOutput("redir_wait_addr", mem.imem_addr, 32'h20);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        stepCycle();
        checkOutput("redir_newest_addr", mem.imem_addr, 32'h200);
        checkBit("redir_drop_valid", valid, 1'b0);
        checkOutput("redir_drop_pc4", pc4, 32'h20);
        stepCycle();
        checkOutput("redir_fetch_pc4", pc4, 32'h204);
        checkOutput("redir_fetch_instr", instr, 32'h1000_0200);
        checkBit("redir_fetch_valid", valid, 1'b1);

        // Ack, stall and redirect together: no HOLD, flush, refetch 0x40
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1);
        stepCycle();
        checkOutput("combo_addr", mem.imem_addr, 32'h40);
        checkBit("combo_req", mem.imem_req, 1'b1);
        checkBit("combo_valid", valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        stepCycle();
        checkOutput("combo_next_pc4", pc4, 32'h44);
        checkBit("combo_next_valid", valid, 1'b1);

        // Redirect while in HOLD drops the buffered word
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        stepCycle();
        checkBit("hold_req", mem.imem_req, 1'b0);
        checkOutput("hold_pc4", pc4, 32'h44);
        applyStimulus(1'b1, 1'b1, 32'h80, 1'b0);
        stepCycle();
        checkOutput("hold_redir_addr", mem.imem_addr, 32'h80);
        checkBit("hold_redir_req", mem.imem_req, 1'b1);
        checkBit("hold_redir_valid", valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

        // Late ack arriving in START is ignored
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        stepCycle();
        rst_n = 1'b1;
        checkBit("late_start_req", mem.imem_req, 1'b0);
        stepCycle();
        checkOutput("late_addr", mem.imem_addr, 32'h0);
        checkBit("late_valid", valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

        // PC wrap from RESET_PC = 0xFFFF_FFFC
        checkOutput("wrap_rst_addr", memW.imem_addr, 32'hFFFF_FFFC);
        rstW_n = 1'b1;
        stepCycle();
        checkOutput("wrap_addr0", memW.imem_addr, 32'hFFFF_FFFC);
        stepCycle();
        checkOutput("wrap_pc4", wPc4, 32'h0);
        checkBit("wrap_valid", wValid, 1'b1);
        checkOutput("wrap_instr", wInstr, 32'h0FFF_FFFC);
        checkOutput("wrap_addr1", memW.imem_addr, 32'h0);
        stepCycle();
        checkOutput("wrap_pc4_next", wPc4, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
